// File: rtl/multi_cycle_core.sv
// Multi-cycle RV32I-subset core (add/sub/and/or/slt/addi/lw/sw/beq/jal) on one unified memory port.
// Define MULTI_CYCLE_CORE_ILLEGAL_HALT_EN to halt on illegal instructions instead of treating them as NOPs.
module multi_cycle_core #(
   parameter int unsigned ADDR_W   = 32,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready,
   output logic              halted,
   output logic [ADDR_W-1:0] pc_dbg
);

   typedef enum logic [2:0] {
      StFetch, StDecode, StExec, StMemRd, StMemWr, StWb, StHalt
   } state_e;

   localparam logic [ADDR_W-1:0] AlignMask = {{(ADDR_W-2){1'b1}}, 2'b00};

   state_e            r_state, w_state_next;
   logic [ADDR_W-1:0] r_pc, r_oldpc;
   logic [31:0]       r_ir, r_a, r_b, r_aluout, r_mdr;
   logic [31:0]       r_rf [32];

   logic [6:0]  w_opcode, w_f7;
   logic [4:0]  w_rd, w_rs1, w_rs2;
   logic [2:0]  w_f3;
   logic        w_is_r, w_is_addi, w_is_lw, w_is_sw, w_is_beq, w_is_jal, w_legal;
   logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j;
   logic [31:0] w_rs1_val, w_rs2_val, w_alu_res, w_addr_sum;
   logic [31:0] w_oldpc_ext, w_link, w_br_tgt, w_jal_tgt;

   assign w_opcode = r_ir[6:0];
   assign w_rd     = r_ir[11:7];
   assign w_f3     = r_ir[14:12];
   assign w_rs1    = r_ir[19:15];
   assign w_rs2    = r_ir[24:20];
   assign w_f7     = r_ir[31:25];

   assign w_is_r    = (w_opcode == 7'b0110011) &&
                      (((w_f7 == 7'b0000000) && ((w_f3 == 3'b000) || (w_f3 == 3'b111) ||
                                                 (w_f3 == 3'b110) || (w_f3 == 3'b010))) ||
                       ((w_f7 == 7'b0100000) && (w_f3 == 3'b000)));
   assign w_is_addi = (w_opcode == 7'b0010011) && (w_f3 == 3'b000);
   assign w_is_lw   = (w_opcode == 7'b0000011) && (w_f3 == 3'b010);
   assign w_is_sw   = (w_opcode == 7'b0100011) && (w_f3 == 3'b010);
   assign w_is_beq  = (w_opcode == 7'b1100011) && (w_f3 == 3'b000);
   assign w_is_jal  = (w_opcode == 7'b1101111);
   assign w_legal   = w_is_r | w_is_addi | w_is_lw | w_is_sw | w_is_beq | w_is_jal;

   assign w_imm_i = {{20{r_ir[31]}}, r_ir[31:20]};
   assign w_imm_s = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
   assign w_imm_b = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
   assign w_imm_j = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};

   assign w_rs1_val  = (w_rs1 == 5'd0) ? 32'd0 : r_rf[w_rs1];
   assign w_rs2_val  = (w_rs2 == 5'd0) ? 32'd0 : r_rf[w_rs2];
   assign w_addr_sum = r_a + (w_is_sw ? w_imm_s : w_imm_i);

   // PC arithmetic runs in 32 bits and is truncated back to ADDR_W on the way into r_pc.
   always_comb begin
      w_oldpc_ext                = '0;
      w_oldpc_ext[ADDR_W-1:0]    = r_oldpc;
      w_link                     = '0;
      w_link[ADDR_W-1:0]         = r_oldpc + ADDR_W'(4);
   end
   assign w_br_tgt  = w_oldpc_ext + w_imm_b;
   assign w_jal_tgt = w_oldpc_ext + w_imm_j;

   always_comb begin
      w_alu_res = '0;
      if (w_is_addi) begin
         w_alu_res = r_a + w_imm_i;
      end else begin
         case ({w_f7[5], w_f3})
            4'b0000: w_alu_res = r_a + r_b;
            4'b1000: w_alu_res = r_a - r_b;
            4'b0111: w_alu_res = r_a & r_b;
            4'b0110: w_alu_res = r_a | r_b;
            4'b0010: w_alu_res = {31'd0, $signed(r_a) < $signed(r_b)};
            default: w_alu_res = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= StFetch;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         StFetch:  if (mem_ready) w_state_next = StDecode;
         StDecode: begin
            if (w_legal) begin
               w_state_next = StExec;
            end else begin
`ifdef MULTI_CYCLE_CORE_ILLEGAL_HALT_EN
               w_state_next = StHalt;
`else
               w_state_next = StFetch;
`endif
            end
         end
         StExec: begin
            if (w_is_r || w_is_addi) w_state_next = StWb;
            else if (w_is_lw)        w_state_next = StMemRd;
            else if (w_is_sw)        w_state_next = StMemWr;
            else                     w_state_next = StFetch;
         end
         StMemRd:  if (mem_ready) w_state_next = StWb;
         StMemWr:  if (mem_ready) w_state_next = StFetch;
         StWb:     w_state_next = StFetch;
         StHalt:   w_state_next = StHalt;
         default:  w_state_next = StFetch;
      endcase
   end

   // Requests are gated by rst so an in-flight access drops the moment reset asserts.
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = r_pc & AlignMask;
      mem_wdata = r_b;
      case (r_state)
         StFetch: mem_req = 1'b1;
         StMemRd: begin
            mem_req  = 1'b1;
            mem_addr = r_aluout[ADDR_W-1:0] & AlignMask;
         end
         StMemWr: begin
            mem_req  = 1'b1;
            mem_we   = 1'b1;
            mem_addr = r_aluout[ADDR_W-1:0] & AlignMask;
         end
         default: mem_req = 1'b0;
      endcase
      if (rst) begin
         mem_req = 1'b0;
         mem_we  = 1'b0;
      end
`ifdef MULTI_CYCLE_CORE_ILLEGAL_HALT_EN
      halted = (r_state == StHalt);
`else
      halted = 1'b0;
`endif
   end

   assign pc_dbg = r_pc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc     <= RESET_PC[ADDR_W-1:0];
         r_oldpc  <= '0;
         r_ir     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_aluout <= '0;
         r_mdr    <= '0;
         for (int i = 0; i < 32; i++) r_rf[i] <= '0;
      end else begin
         case (r_state)
            StFetch: begin
               if (mem_ready) begin
                  r_ir    <= mem_rdata;
                  r_oldpc <= r_pc;
                  r_pc    <= r_pc + ADDR_W'(4);
               end
            end
            StDecode: begin
               r_a <= w_rs1_val;
               r_b <= w_rs2_val;
            end
            StExec: begin
               if (w_is_r || w_is_addi) r_aluout <= w_alu_res;
               if (w_is_lw || w_is_sw)  r_aluout <= w_addr_sum;
               if (w_is_beq && (r_a == r_b)) r_pc <= w_br_tgt[ADDR_W-1:0];
               if (w_is_jal) begin
                  r_pc <= w_jal_tgt[ADDR_W-1:0];
                  if (w_rd != 5'd0) r_rf[w_rd] <= w_link;
               end
            end
            StMemRd: if (mem_ready) r_mdr <= mem_rdata;
            StWb:    if (w_rd != 5'd0) r_rf[w_rd] <= w_is_lw ? r_mdr : r_aluout;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multi_cycle_core.sv
// Scoreboard bench for multi_cycle_core: directed programs push expected bus transactions,
// a negedge monitor pops and compares every completed memory access.
module tb_multi_cycle_core;

   typedef struct {
      int          cyc;
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } txn_t;

   logic        clk, rst;
   logic        mem_req, mem_we, mem_ready, halted;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_dbg;
   logic [31:0] mem [1024];
   txn_t        q[$];
   txn_t        m_t;
   int          cyc, e_cyc, n_checks, n_fail;

   multi_cycle_core #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .halted    (halted),
      .pc_dbg    (pc_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // While stalled the bus carries a legal but wrong instruction (addi x1,x0,99).
   assign mem_rdata = mem_ready ? mem[mem_addr[11:2]] : 32'h0630_0093;

   always @(posedge clk) begin
      if (!rst && mem_req && mem_we && mem_ready) mem[mem_addr[11:2]] = mem_wdata;
   end

   always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && mem_req && mem_ready && q.size() > 0) begin
         m_t = q.pop_front();
         chk("txn_cycle", 32'(cyc), 32'(m_t.cyc));
         chk("txn_we", {31'd0, mem_we}, {31'd0, m_t.we});
         chk("txn_addr", mem_addr, m_t.addr);
         if (m_t.we) chk("txn_wdata", mem_wdata, m_t.data);
      end
   end

   function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
      logic [31:0] v;
      v = imm;
      return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
   endfunction
   function automatic logic [31:0] addi(int rd, int rs1, int imm);
      return enc_i(imm, rs1, 0, rd, 7'b0010011);
   endfunction
   function automatic logic [31:0] lw(int rd, int rs1, int imm);
      return enc_i(imm, rs1, 2, rd, 7'b0000011);
   endfunction
   function automatic logic [31:0] rop(int f7, int f3, int rd, int rs1, int rs2);
      return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'b0110011};
   endfunction
   function automatic logic [31:0] sw(int rs2, int rs1, int imm);
      logic [31:0] v;
      v = imm;
      return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] beq(int rs1, int rs2, int imm);
      logic [31:0] v;
      v = imm;
      return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'b000, v[4:1], v[11], 7'b1100011};
   endfunction
   function automatic logic [31:0] jal(int rd, int imm);
      logic [31:0] v;
      v = imm;
      return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'b1101111};
   endfunction

   task automatic push(input int c, input logic we, input logic [31:0] a, input logic [31:0] d);
      txn_t t;
      t.cyc = c; t.we = we; t.addr = a; t.data = d;
      q.push_back(t);
   endtask
   // Expected bus activity per instruction class, with mem_ready high throughout.
   task automatic t_alu(input logic [31:0] pc);
      push(e_cyc, 1'b0, pc, 32'd0); e_cyc += 4;
   endtask
   task automatic t_br(input logic [31:0] pc);
      push(e_cyc, 1'b0, pc, 32'd0); e_cyc += 3;
   endtask
   task automatic t_sw(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] d);
      push(e_cyc, 1'b0, pc, 32'd0); push(e_cyc + 3, 1'b1, a, d); e_cyc += 4;
   endtask
   task automatic t_lw(input logic [31:0] pc, input logic [31:0] a);
      push(e_cyc, 1'b0, pc, 32'd0); push(e_cyc + 3, 1'b0, a, 32'd0); e_cyc += 5;
   endtask

   task automatic begin_test();
      @(posedge clk); #1;
      rst = 1'b1; mem_ready = 1'b1; q.delete(); e_cyc = 0;
      for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
   endtask
   task automatic put(input int addr, input logic [31:0] w);
      mem[addr >> 2] = w;
   endtask
   task automatic go();
      @(posedge clk); #1;
      rst = 1'b0;
   endtask
   task automatic end_test(input int n);
      repeat (n) @(posedge clk);
      chk("queue_drained", 32'(q.size()), 32'd0);
      q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      logic [31:0] exp_a [7];
      logic [31:0] exp_d [7];
      n_checks = 0; n_fail = 0; e_cyc = 0;
      rst = 1'b1; mem_ready = 1'b1;
      for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
      repeat (2) @(posedge clk); #1;
      chk("rst_req", {31'd0, mem_req}, 32'd0);
      chk("rst_we", {31'd0, mem_we}, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      chk("rst_pc", pc_dbg, 32'd0);

      // addi chain, then store the result
      begin_test();
      put(0, addi(5, 0, 7)); put(4, addi(1, 5, -9)); put(8, sw(1, 0, 32'h200)); put(12, jal(0, 0));
      t_alu(0); t_alu(4); t_sw(8, 32'h200, 32'hFFFF_FFFE); t_br(12);
      go();
      repeat (3) @(posedge clk); @(negedge clk);
      chk("addi_pc4", pc_dbg, 32'd4);
      repeat (4) @(posedge clk); @(negedge clk);
      chk("addi_pc8", pc_dbg, 32'd8);
      end_test(8);
      chk("addi_mem", mem[32'h200 >> 2], 32'hFFFF_FFFE);

      // store then load the same word
      begin_test();
      put(0, lw(2, 0, 40)); put(4, jal(0, 12)); put(16, sw(2, 0, 8)); put(20, lw(3, 0, 8));
      put(24, sw(3, 0, 12)); put(28, jal(0, 0)); put(40, 32'hDEAD_BEEF);
      t_lw(0, 40); t_br(4); t_sw(16, 8, 32'hDEAD_BEEF); t_lw(20, 8);
      t_sw(24, 12, 32'hDEAD_BEEF); t_br(28);
      go();
      end_test(24);

      // taken beq, with jal link observed through a store
      begin_test();
      put(0, jal(9, 16)); put(16, beq(0, 0, -4)); put(12, sw(9, 0, 32'h200));
      t_br(0); t_br(16); t_sw(12, 32'h200, 32'd4); t_br(16);
      go();
      end_test(14);

      // beq not taken falls through
      begin_test();
      put(0, addi(1, 0, 1)); put(4, jal(0, 12)); put(16, beq(1, 0, -4)); put(20, jal(0, 0));
      t_alu(0); t_br(4); t_br(16); t_br(20);
      go();
      end_test(14);

      // fetch stalled three cycles
      begin_test();
      put(0, addi(1, 0, 5)); put(4, sw(1, 0, 32'h200)); put(8, jal(0, 0));
      mem_ready = 1'b0;
      e_cyc = 3; t_alu(0); t_sw(4, 32'h200, 32'd5); t_br(8);
      go();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("stall_req", {31'd0, mem_req}, 32'd1);
         chk("stall_addr", mem_addr, 32'd0);
         chk("stall_pc", pc_dbg, 32'd0);
         @(posedge clk); #1;
         if (k == 2) mem_ready = 1'b1;
      end
      @(negedge clk);
      chk("stall_pc_after", pc_dbg, 32'd4);
      end_test(10);
      chk("stall_mem", mem[32'h200 >> 2], 32'd5);

      // reset asserted during MEMWR
      begin_test();
      put(0, addi(1, 0, 9)); put(4, sw(1, 0, 32'h200)); put(8, jal(0, 0));
      t_alu(0); push(4, 1'b0, 32'd4, 32'd0);
      go();
      repeat (7) @(posedge clk); #1;
      chk("memwr_req", {31'd0, mem_req}, 32'd1);
      chk("memwr_we", {31'd0, mem_we}, 32'd1);
      rst = 1'b1; #1;
      chk("abort_req", {31'd0, mem_req}, 32'd0);
      chk("abort_we", {31'd0, mem_we}, 32'd0);
      chk("abort_pc", pc_dbg, 32'd0);
      chk("queue_drained", 32'(q.size()), 32'd0);
      @(posedge clk); #1;
      chk("abort_no_write", mem[32'h200 >> 2], 32'd0);
      e_cyc = 0; t_alu(0); t_sw(4, 32'h200, 32'd9); t_br(8);
      go();
      @(negedge clk);
      chk("restart_req", {31'd0, mem_req}, 32'd1);
      chk("restart_addr", mem_addr, 32'd0);
      end_test(12);
      chk("restart_mem", mem[32'h200 >> 2], 32'd9);

      // illegal opcode 7'h7F
      begin_test();
      put(0, 32'h0000_007F); put(4, addi(1, 0, 3)); put(8, sw(1, 0, 32'h200)); put(12, jal(0, 0));
`ifdef MULTI_CYCLE_CORE_ILLEGAL_HALT_EN
      push(0, 1'b0, 32'd0, 32'd0);
      go();
      repeat (2) @(posedge clk); @(negedge clk);
      chk("halt_flag", {31'd0, halted}, 32'd1);
      chk("halt_pc", pc_dbg, 32'd4);
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (mem_req) cnt++;
      end
      chk("halt_no_req", 32'(cnt), 32'd0);
      chk("halt_hold", {31'd0, halted}, 32'd1);
      end_test(1);
`else
      push(0, 1'b0, 32'd0, 32'd0); e_cyc = 2;
      t_alu(4); t_sw(8, 32'h200, 32'd3); t_br(12);
      go();
      repeat (2) @(posedge clk); @(negedge clk);
      chk("nop_halted", {31'd0, halted}, 32'd0);
      chk("nop_fetch", mem_addr, 32'd4);
      end_test(12);
      chk("nop_halted_end", {31'd0, halted}, 32'd0);
`endif

      // R-type ALU ops, x0 write discard, unaligned store address
      begin_test();
      put(0, addi(1, 0, -5)); put(4, addi(2, 0, 3));
      put(8, rop(0, 0, 3, 1, 2)); put(12, rop(32, 0, 4, 2, 1));
      put(16, rop(0, 7, 5, 1, 2)); put(20, rop(0, 6, 6, 1, 2));
      put(24, rop(0, 2, 7, 1, 2)); put(28, rop(0, 2, 8, 2, 1));
      put(32, addi(0, 1, 0));
      put(36, sw(3, 0, 32'h200)); put(40, sw(4, 0, 32'h204)); put(44, sw(5, 0, 32'h208));
      put(48, sw(6, 0, 32'h20C)); put(52, sw(7, 0, 32'h212)); put(56, sw(8, 0, 32'h214));
      put(60, sw(0, 0, 32'h218)); put(64, jal(0, 0));
      exp_a = '{32'h200, 32'h204, 32'h208, 32'h20C, 32'h210, 32'h214, 32'h218};
      exp_d = '{32'hFFFF_FFFE, 32'd8, 32'd3, 32'hFFFF_FFFB, 32'd1, 32'd0, 32'd0};
      for (int i = 0; i < 9; i++) t_alu(32'(i * 4));
      for (int i = 0; i < 7; i++) t_sw(32'(36 + i * 4), exp_a[i], exp_d[i]);
      t_br(64);
      go();
      end_test(70);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/multi_cycle_core.md
MULTI_CYCLE_CORE -- requirements
Module: multi_cycle_core

Interface
REQ-001 Parameter ADDR_W, default 32: width of the memory byte address and PC. Legal range is 8..32.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: PC value after reset, truncated to ADDR_W.
REQ-003 Port clk, input, 1: single clock, rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Port mem_req, output, 1: memory request valid.
REQ-006 Port mem_we, output, 1: 1 = write, 0 = read; valid while mem_req=1.
REQ-007 Port mem_addr, output, ADDR_W: byte address, always word-aligned (bits[1:0]=0).
REQ-008 Port mem_wdata, output, 32: store data.
REQ-009 Port mem_rdata, input, 32: read data; valid in the cycle mem_ready=1.
REQ-010 Port mem_ready, input, 1: memory completes the current request at this edge.
REQ-011 Port halted, output, 1: core is in HALT.
REQ-012 Port pc_dbg, output, ADDR_W: current PC.

Function
REQ-013 Supported instructions (RV32I subset): add, sub, and, or, slt, addi, lw, sw, beq, jal.
REQ-014 Memory is unified for instruction and data; one port is used for both.
REQ-015 Register file is internal, 32x32; x0 reads 0, and writes to x0 are discarded.
REQ-016 FSM states: FETCH, DECODE, EXEC, MEMRD, MEMWR, WB, HALT.
REQ-017 Handshake: while mem_req=1, mem_addr/mem_we/mem_wdata hold stable until an edge with mem_ready=1. mem_ready while mem_req=0 is ignored.
REQ-018 FETCH: mem_req=1, mem_we=0, mem_addr=PC. On mem_ready: IR<=mem_rdata, OLDPC<=PC, PC<=PC+4, go to DECODE. Otherwise stay in FETCH.
REQ-019 DECODE (1 cycle): A<=rs1, B<=rs2, immediate is sign-extended per format, go to EXEC.
REQ-020 EXEC for R-type and addi: ALUOUT<=result, go to WB.
REQ-021 EXEC for lw and sw: ALUOUT<=A+imm. lw goes to MEMRD; sw goes to MEMWR.
REQ-022 EXEC for beq: if A==B then PC<=OLDPC+imm_B; go to FETCH.
REQ-023 EXEC for jal: rd<=OLDPC+4 and PC<=OLDPC+imm_J; go to FETCH.
REQ-024 MEMRD: read request at ALUOUT. On mem_ready, MDR<=mem_rdata and go to WB.
REQ-025 MEMWR: write request at ALUOUT with mem_wdata=B. On mem_ready, go to FETCH.
REQ-026 WB (1 cycle): rd<=ALUOUT, or MDR for lw; go to FETCH.
REQ-027 Latency with mem_ready tied high: R/addi 4 cycles, lw 5, sw 4, beq 3, jal 3.
REQ-028 All arithmetic is 32-bit modulo 2^32. slt is signed. Addresses are truncated to ADDR_W and wrap from all-ones to 0.
REQ-029 Data addresses with bits[1:0]!=0 are forced to the aligned address; the low 2 bits are ignored.
REQ-030 mem_req=0 in DECODE, EXEC, WB and HALT.

Reset
REQ-031 While rst=1, regardless of clk: state=FETCH, PC=RESET_PC, IR/OLDPC/A/B/ALUOUT/MDR=0, all registers x1..x31=0, mem_req=0, mem_we=0, halted=0.
REQ-032 Reset asserted mid-transaction aborts that transaction. No register write from the aborted instruction occurs.
REQ-033 On the first rising edge after rst deasserts, mem_req=1 with mem_addr=RESET_PC.

Configuration
REQ-034 Macro MULTI_CYCLE_CORE_ILLEGAL_HALT_EN controls handling of any opcode/funct combination outside REQ-013.
- Defined: an illegal combination detected in DECODE moves the core to HALT. In HALT, halted=1, PC is frozen at OLDPC+4, and no further requests are issued until reset.
- Undefined: an illegal combination executes as a NOP (DECODE→FETCH, 2 cycles), and halted is constant 0.

Verification
REQ-035 Memory has x5=7 preloaded; ready is always 1; program is addi x1,x5,-9. Required: x1=32'hFFFF_FFFE after 4 cycles, and pc_dbg=4.
REQ-036 Program sw x2,8(x0) with x2=32'hDEAD_BEEF, then lw x3,8(x0). Required: write at address 8 with that data, then x3=32'hDEAD_BEEF; total 9 cycles.
REQ-037 beq x0,x0,-4 at PC=16. Required: next fetch address 12 after 3 cycles. With x1=1, beq x1,x0,-4 falls through to 20.
REQ-038 Fetch with mem_ready low for 3 cycles. Required: mem_addr/mem_req held stable for 4 cycles, and IR loads only on the ready edge.
REQ-039 Assert rst during MEMWR. Required: mem_req drops immediately, PC=RESET_PC, and the next request is a fetch at RESET_PC.
REQ-040 Issue opcode 7'h7F. With the macro defined: halted=1 after 2 cycles, and mem_req stays 0 for 20 cycles. Without the macro: the fetch at PC+4 follows.
